// File: rtl/micro_ctrl_unit.sv
// micro_ctrl_unit: Moore microsequencer producing the 29-bit execution-unit
// control word, memory strobes with ready handshake and a wait-timeout watchdog.
module micro_ctrl_unit #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      ire,
   input  logic [3:0]       cc,
   input  logic             mem_ready,
   output logic [28:0]      cwrd,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic             halted,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int unsigned WAIT_W = 8;
   localparam int unsigned OP_W   = 6;

   typedef enum logic [3:0] {
      S_F0, S_F1, S_F2, S_DEC, S_DSP,
      S_ALU0, S_ALU1, S_MOV,
      S_LD0, S_LD1, S_LD2,
      S_ST0, S_ST1, S_ST2,
      S_JMP, S_HALT
   } state_t;

   typedef struct packed {
      logic [1:0] ao;
      logic [1:0] pc;
      logic [1:0] t2;
      logic [3:0] rf;
      logic [1:0] t1;
      logic [2:0] alu;
      logic [1:0] di;
      logic       dout;
      logic [1:0] ire_sel;
      logic [1:0] irf;
      logic [6:0] pad;
   } ctrl_word_t;

   state_t             state;
   state_t             state_nxt;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [WAIT_W-1:0]  wait_nxt;
   logic               retire;
   logic               set_illegal;
   logic               set_bus_err;
   logic [OP_W-1:0]    opcode;
   logic               unused_bits;

   assign opcode      = ire[15:10];
   assign unused_bits = ^{ire[9:0], cc[3:1]};

   // Control word for each state; unlisted fields stay zero.
   function automatic ctrl_word_t decode_cw(input state_t s);
      ctrl_word_t cw;
      cw = '0;
      case (s)
         S_F0:   begin cw.ao = 2'b01; cw.pc = 2'b01; cw.alu = 3'b001; end
         S_F1:   cw.irf = 2'b01;
         S_F2:   begin cw.t1 = 2'b01; cw.pc = 2'b10; end
         S_DEC:  cw.irf = 2'b10;
         S_ALU0: begin cw.rf = 4'b1011; cw.alu = 3'b100; end
         S_ALU1: begin cw.t1 = 2'b10; cw.rf = 4'b0001; end
         S_MOV:  cw.rf = 4'b0110;
         S_LD0:  begin cw.rf = 4'b0010; cw.ao = 2'b01; end
         S_LD1:  cw.di = 2'b01;
         S_LD2:  begin cw.di = 2'b10; cw.rf = 4'b0001; end
         S_ST0:  begin cw.rf = 4'b0010; cw.ao = 2'b01; end
         S_ST1:  begin cw.rf = 4'b0011; cw.dout = 1'b1; end
         S_JMP:  begin cw.rf = 4'b0010; cw.pc = 2'b10; end
         default: cw = '0;
      endcase
      return cw;
   endfunction

   // Next-state, wait counter and retire/flag events.
   always_comb begin
      state_nxt   = state;
      wait_nxt    = '0;
      retire      = 1'b0;
      set_illegal = 1'b0;
      set_bus_err = 1'b0;
      case (state)
         S_F0:  state_nxt = S_F1;
         S_F1, S_LD1, S_ST2: begin
            if (mem_ready) begin
               case (state)
                  S_F1:    state_nxt = S_F2;
                  S_LD1:   state_nxt = S_LD2;
                  default: begin state_nxt = S_F0; retire = 1'b1; end
               endcase
            end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
               state_nxt   = S_HALT;
               set_bus_err = 1'b1;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         S_F2:  state_nxt = S_DEC;
         S_DEC: state_nxt = S_DSP;
         S_DSP: begin
            if (opcode[5:3] == 3'b000) begin
               state_nxt = S_ALU0;
            end else begin
               case (opcode)
                  6'b001000: state_nxt = S_MOV;
                  6'b001001: state_nxt = S_LD0;
                  6'b001010: state_nxt = S_ST0;
                  6'b001011: begin
                     if (cc[0]) begin
                        state_nxt = S_JMP;
                     end else begin
                        state_nxt = S_F0;
                        retire    = 1'b1;
                     end
                  end
                  6'b001100: state_nxt = S_JMP;
                  6'b111111: state_nxt = S_HALT;
                  default: begin
                     state_nxt   = S_F0;
                     retire      = 1'b1;
                     set_illegal = 1'b1;
                  end
               endcase
            end
         end
         S_ALU0: state_nxt = S_ALU1;
         S_ALU1, S_MOV, S_LD2, S_JMP: begin
            state_nxt = S_F0;
            retire    = 1'b1;
         end
         S_LD0:  state_nxt = S_LD1;
         S_ST0:  state_nxt = S_ST1;
         S_ST1:  state_nxt = S_ST2;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_F0;
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_F0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Moore outputs registered from the next state so they track the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cwrd   <= decode_cw(S_F0);
         mem_rd <= 1'b0;
         mem_wr <= 1'b0;
         halted <= 1'b0;
      end else begin
         cwrd   <= decode_cw(state_nxt);
         mem_rd <= (state_nxt == S_F1) || (state_nxt == S_LD1);
         mem_wr <= (state_nxt == S_ST2);
         halted <= (state_nxt == S_HALT);
      end
   end

   // Sticky error flags and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal   <= 1'b0;
         bus_err   <= 1'b0;
         instr_cnt <= '0;
      end else begin
         if (set_illegal) illegal <= 1'b1;
         if (set_bus_err) bus_err <= 1'b1;
         if (retire)      instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_micro_ctrl_unit.sv
// Scoreboard bench for micro_ctrl_unit: expected per-cycle outputs are queued
// as each cycle's stimulus is applied and compared after the clock edge.
module tb_micro_ctrl_unit;

   localparam int unsigned CNT_W = 4;

   localparam int F0 = 0, F1 = 1, F2 = 2, DEC = 3, DSP = 4, ALU0 = 5, ALU1 = 6,
                  MOV = 7, LD0 = 8, LD1 = 9, LD2 = 10, ST0 = 11, ST1 = 12,
                  ST2 = 13, JMP = 14, HALT = 15;

   typedef struct {
      logic [28:0]      cwrd;
      logic             rd;
      logic             wr;
      logic             halt;
      logic             ill;
      logic             berr;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [15:0]      ire;
   logic [3:0]       cc;
   logic             mem_ready;
   logic [28:0]      cwrd;
   logic             mem_rd;
   logic             mem_wr;
   logic             halted;
   logic             illegal;
   logic             bus_err;
   logic [CNT_W-1:0] instr_cnt;

   int               n_chk;
   int               n_fail;
   exp_t             sb[$];
   logic [CNT_W-1:0] exp_cnt;
   logic             exp_ill;
   logic             exp_berr;

   micro_ctrl_unit #(.MAX_WAIT(15), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ire       (ire),
      .cc        (cc),
      .mem_ready (mem_ready),
      .cwrd      (cwrd),
      .mem_rd    (mem_rd),
      .mem_wr    (mem_wr),
      .halted    (halted),
      .illegal   (illegal),
      .bus_err   (bus_err),
      .instr_cnt (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Assemble a control word from its fields.
   function automatic logic [28:0] cw(input int ao, input int pc, input int rf, input int t1,
                                      input int alu, input int di, input int dout, input int irf);
      logic [28:0] v;
      v        = '0;
      v[28:27] = 2'(ao);
      v[26:25] = 2'(pc);
      v[22:19] = 4'(rf);
      v[18:17] = 2'(t1);
      v[16:14] = 3'(alu);
      v[13:12] = 2'(di);
      v[11]    = 1'(dout);
      v[8:7]   = 2'(irf);
      return v;
   endfunction

   // Expected outputs while sitting in state s.
   function automatic exp_t mk(input int s);
      exp_t e;
      e.cwrd = '0;
      e.rd   = (s == F1) || (s == LD1);
      e.wr   = (s == ST2);
      e.halt = (s == HALT);
      e.ill  = exp_ill;
      e.berr = exp_berr;
      e.cnt  = exp_cnt;
      case (s)
         F0:   e.cwrd = cw(1, 1, 0, 0, 1, 0, 0, 0);
         F1:   e.cwrd = cw(0, 0, 0, 0, 0, 0, 0, 1);
         F2:   e.cwrd = cw(0, 2, 0, 1, 0, 0, 0, 0);
         DEC:  e.cwrd = cw(0, 0, 0, 0, 0, 0, 0, 2);
         ALU0: e.cwrd = cw(0, 0, 11, 0, 4, 0, 0, 0);
         ALU1: e.cwrd = cw(0, 0, 1, 2, 0, 0, 0, 0);
         MOV:  e.cwrd = cw(0, 0, 6, 0, 0, 0, 0, 0);
         LD0:  e.cwrd = cw(1, 0, 2, 0, 0, 0, 0, 0);
         LD1:  e.cwrd = cw(0, 0, 0, 0, 0, 1, 0, 0);
         LD2:  e.cwrd = cw(0, 0, 1, 0, 0, 2, 0, 0);
         ST0:  e.cwrd = cw(1, 0, 2, 0, 0, 0, 0, 0);
         ST1:  e.cwrd = cw(0, 0, 3, 0, 0, 0, 1, 0);
         JMP:  e.cwrd = cw(0, 2, 2, 0, 0, 0, 0, 0);
         default: e.cwrd = '0;
      endcase
      return e;
   endfunction

   // Apply one cycle of stimulus, queue the expected post-edge outputs, then compare.
   task automatic step(input logic rdy, input int s, input bit ret = 1'b0);
      exp_t e;
      mem_ready = rdy;
      if (ret) exp_cnt = exp_cnt + CNT_W'(1);
      sb.push_back(mk(s));
      @(posedge clk);
      #1;
      chk("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk($sformatf("cwrd_s%0d", s),  32'(cwrd),      32'(e.cwrd));
         chk($sformatf("rd_s%0d", s),    32'(mem_rd),    32'(e.rd));
         chk($sformatf("wr_s%0d", s),    32'(mem_wr),    32'(e.wr));
         chk($sformatf("halt_s%0d", s),  32'(halted),    32'(e.halt));
         chk($sformatf("ill_s%0d", s),   32'(illegal),   32'(e.ill));
         chk($sformatf("berr_s%0d", s),  32'(bus_err),   32'(e.berr));
         chk($sformatf("cnt_s%0d", s),   32'(instr_cnt), 32'(e.cnt));
      end
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // F0 -> F1 -> F2 -> DEC -> DSP with the given instruction.
   task automatic fetch(input logic [15:0] op);
      ire = op;
      step(rnd(), F1);
      step(1'b1, F2);
      step(rnd(), DEC);
      step(rnd(), DSP);
   endtask

   // Asynchronous reset: outputs must clear without a clock edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_cwrd",   32'(cwrd),      32'h0A00_4000);
      chk("rst_rd",     32'(mem_rd),    32'd0);
      chk("rst_wr",     32'(mem_wr),    32'd0);
      chk("rst_halt",   32'(halted),    32'd0);
      chk("rst_ill",    32'(illegal),   32'd0);
      chk("rst_berr",   32'(bus_err),   32'd0);
      chk("rst_cnt",    32'(instr_cnt), 32'd0);
      sb.delete();
      exp_cnt  = '0;
      exp_ill  = 1'b0;
      exp_berr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", n_chk);
      $fatal(1);
   end

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b1;
      ire       = '0;
      cc        = '0;
      mem_ready = 1'b0;
      exp_cnt   = '0;
      exp_ill   = 1'b0;
      exp_berr  = 1'b0;
      #2;
      do_reset();

      // ADD
      fetch(16'h0012);
      step(rnd(), ALU0);
      step(rnd(), ALU1);
      step(rnd(), F0, 1'b1);

      // JZ taken then not taken
      cc = 4'b0001;
      fetch(16'h2C00);
      step(rnd(), JMP);
      step(rnd(), F0, 1'b1);
      cc = 4'b0000;
      fetch(16'h2C00);
      step(rnd(), F0, 1'b1);

      // MOV
      fetch(16'h2000);
      step(rnd(), MOV);
      step(rnd(), F0, 1'b1);

      // LD with three wait cycles
      fetch(16'h2400);
      step(rnd(), LD0);
      step(rnd(), LD1);
      repeat (3) step(1'b0, LD1);
      step(1'b1, LD2);
      step(rnd(), F0, 1'b1);

      // ST with one wait cycle
      fetch(16'h2800);
      step(rnd(), ST0);
      step(rnd(), ST1);
      step(rnd(), ST2);
      step(1'b0, ST2);
      step(1'b1, F0, 1'b1);

      // unconditional JMP
      fetch(16'h3000);
      step(rnd(), JMP);
      step(rnd(), F0, 1'b1);

      // illegal opcode, then a normal fetch proceeds
      fetch(16'h4000);
      exp_ill = 1'b1;
      step(rnd(), F0, 1'b1);
      cc = 4'($urandom_range(0, 15));
      fetch(16'h1C05);
      step(rnd(), ALU0);
      step(rnd(), ALU1);
      step(rnd(), F0, 1'b1);

      // enough MOVs to wrap the retire counter
      for (int i = 0; i < 12; i++) begin
         fetch(16'h2000);
         step(rnd(), MOV);
         step(rnd(), F0, 1'b1);
      end

      // ready arriving exactly at MAX_WAIT is a success
      ire = 16'h2000;
      step(rnd(), F1);
      repeat (15) step(1'b0, F1);
      step(1'b1, F2);
      step(rnd(), DEC);
      step(rnd(), DSP);
      step(rnd(), MOV);
      step(rnd(), F0, 1'b1);

      // timeout in F1 halts with bus_err until reset
      step(rnd(), F1);
      repeat (15) step(1'b0, F1);
      exp_berr = 1'b1;
      step(1'b0, HALT);
      repeat (4) step(rnd(), HALT);
      do_reset();

      // HALT opcode ignores mem_ready
      fetch(16'hFC00);
      step(rnd(), HALT);
      step(1'b1, HALT);
      step(1'b0, HALT);
      step(1'b1, HALT);
      do_reset();

      // reset in the middle of ST2 drops mem_wr at once
      fetch(16'h2800);
      step(rnd(), ST0);
      step(rnd(), ST1);
      step(1'b0, ST2);
      step(1'b0, ST2);
      do_reset();
      step(rnd(), F1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/micro_ctrl_unit.md
Name: micro_ctrl_unit

Overview:
- Moore-style microsequencer that drives the execution unit.
- Generates the 29-bit control word from the fetched instruction (ire) and the condition code (cc) returned by the execution unit.
- Sequences fetch, decode, dispatch and execute, and owns memory read/write strobes with a ready handshake and a timeout watchdog.
- Sits between instruction memory/bus and the execution unit's cwrd input.

Parameters:
MAX_WAIT, 15, wait cycles allowed with mem_ready low before bus error (1..255)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ire  input  16  executing instruction from exec unit; [15:10] opcode
cc  input  4  condition code from exec unit; cc[0]=zero flag
mem_ready  input  1  memory completes current read/write this cycle
cwrd  output  29  control word to exec unit
mem_rd  output  1  memory read strobe
mem_wr  output  1  memory write strobe
halted  output  1  FSM in HALT
illegal  output  1  sticky: undefined opcode dispatched
bus_err  output  1  sticky: memory wait timeout
instr_cnt  output  CNT_W  retired instructions, wraps to 0

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low. Reset forces state F0, instr_cnt=0, illegal=0, bus_err=0, wait counter=0; release is synchronous to the next rising edge.
- cwrd field map: AO[28:27] PC[26:25] T2[24:23] RF[22:19] T1[18:17] ALU[16:14] DI[13:12] DO[11] IRE[10:9] IRF[8:7]; [6:0] always 0. Fields not listed for a state are 0.
- Moore outputs: cwrd, mem_rd, mem_wr and halted decode from the state register only, with no combinational path from inputs. Reset cwrd = 0x0A004000.
- States and per-state outputs:
  - F0: AO=01, PC=01, ALU=001 -> F1.
  - F1: IRF=01, mem_rd=1; hold until mem_ready=1 -> F2.
  - F2: T1=01, PC=10 (pc<=pc+1) -> DEC.
  - DEC: IRF=10 -> DSP.
  - DSP: cwrd=0; dispatch on ire[15:10]:
    - 000000-000111 -> ALU0
    - 001000 -> MOV
    - 001001 -> LD0
    - 001010 -> ST0
    - 001011 -> JMP if cc[0]=1, else F0
    - 001100 -> JMP
    - 111111 -> HALT
    - any other -> F0 with illegal<=1
  - ALU0: RF=1011, ALU=100 -> ALU1.
  - ALU1: T1=10, RF=0001 -> F0.
  - MOV: RF=0110 -> F0.
  - LD0: RF=0010, AO=01 -> LD1.
  - LD1: DI=01, mem_rd=1; hold until mem_ready -> LD2.
  - LD2: DI=10, RF=0001 -> F0.
  - ST0: RF=0010, AO=01 -> ST1.
  - ST1: RF=0011, DO=1 -> ST2.
  - ST2: mem_wr=1; hold until mem_ready -> F0.
  - JMP: RF=0010, PC=10 -> F0.
  - HALT: cwrd=0, halted=1; exits only on reset.
- Retire: instr_cnt increments by 1 on every transition into F0 from ALU1, MOV, LD2, ST2, JMP, or from DSP (not-taken JZ or illegal opcode). It wraps from all-ones to 0.
- Wait counter:
  - Counts cycles spent in F1, LD1 or ST2 with mem_ready=0; clears on leaving those states.
  - When the counter reaches MAX_WAIT with mem_ready still 0: set bus_err, go to HALT, drop mem_rd/mem_wr that cycle.
  - mem_ready=1 on the MAX_WAIT cycle is a success, not a timeout.
- mem_ready outside the wait states is ignored.
- Sticky flags: illegal and bus_err clear only on reset.
- Reset mid-instruction abandons the sequence immediately. No strobe remains asserted once rst_n is low.

Test Plan:
- Reset: rst_n=0 -> cwrd=0x0A004000, mem_rd=0, halted=0, instr_cnt=0. Release -> F1 next cycle with mem_rd=1.
- ADD (ire=0x0000_00xx, opcode 000000), mem_ready held 1 -> cwrd sequence F0,F1,F2,DEC,DSP,ALU0(RF=1011,ALU=100),ALU1(T1=10,RF=0001), back to F0 on cycle 8; instr_cnt=1.
- JZ (opcode 001011): cc=4'b0001 -> JMP state with PC=10 for one cycle. cc=0 -> F0 directly after DSP. instr_cnt increments in both cases.
- LD with mem_ready low 3 cycles in LD1 -> mem_rd=1 and DI=01 for 4 cycles, then LD2 for 1 cycle; bus_err stays 0.
- Timeout: MAX_WAIT=15, mem_ready stuck 0 in F1 -> after 15 wait cycles bus_err=1, halted=1, cwrd=0, mem_rd=0. Remains so until rst_n pulse.
- Illegal opcode 010000 -> illegal=1, FSM back at F0, next fetch proceeds. Opcode 111111 -> halted=1, mem_ready toggling has no effect. rst_n=0 mid-ST2 -> mem_wr drops immediately.
